// File: rtl/pad_stream_adapter.sv
// Stream adapter between the narrow pad ring and the Winograd core: assembles
// pad beats into core words through an ingress FIFO and serialises results back out.
module pad_stream_adapter #(
    parameter int PAD_W      = 10,
    parameter int DATA_W     = 20,
    parameter int TILE_IN    = 16,
    parameter int TILE_OUT   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PAD_W-1:0]  pad_d,
    input  logic              pad_d_vld,
    output logic              pad_d_rdy,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    input  logic              in_ready,
    output logic              in_last,
    input  logic [DATA_W-1:0] out_data,
    input  logic              out_valid,
    input  logic              out_last,
    output logic              out_ready,
    output logic [PAD_W-1:0]  pad_z,
    output logic              pad_z_vld,
    output logic              pad_z_sof,
    output logic              err_frame
);
    localparam int BEATS  = DATA_W / PAD_W;
    localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ICNT_W = (TILE_IN > 1) ? $clog2(TILE_IN) : 1;
    localparam int OCNT_W = (TILE_OUT > 1) ? $clog2(TILE_OUT) : 1;

    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS - 1);
    localparam logic [ICNT_W-1:0] LAST_IN   = ICNT_W'(TILE_IN - 1);
    localparam logic [OCNT_W-1:0] LAST_OUT  = OCNT_W'(TILE_OUT - 1);

    // ---------------- ingress assembly and FIFO ----------------
    logic [BIDX_W-1:0] ibeat_reg;
    logic [DATA_W-1:0] asm_reg;
    logic [DATA_W-1:0] asm_word;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_reg;
    logic [PTR_W:0]    rd_ptr_reg;
    logic [ICNT_W-1:0] icnt_reg;
    logic              fifo_empty;
    logic              fifo_full;
    logic              beat_acc;
    logic              push;
    logic              pop;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    assign in_valid  = !fifo_empty;
    assign pop       = in_valid && in_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still take a beat.
    assign pad_d_rdy = !rst && (!fifo_full || pop);
    assign beat_acc  = pad_d_vld && pad_d_rdy;
    assign push      = beat_acc && (ibeat_reg == LAST_BEAT);

    // The incoming beat overlays its slot so the final beat forms the complete word.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_asm
            assign asm_word[gi*PAD_W +: PAD_W] =
                (ibeat_reg == BIDX_W'(gi)) ? pad_d : asm_reg[gi*PAD_W +: PAD_W];
        end
    endgenerate

    assign in_data = in_valid ? fifo_mem[rd_ptr_reg[PTR_W-1:0]] : '0;
    assign in_last = in_valid && (icnt_reg == LAST_IN);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= asm_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ibeat_reg  <= '0;
            asm_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            icnt_reg   <= '0;
        end else begin
            if (beat_acc) begin
                asm_reg   <= asm_word;
                ibeat_reg <= (ibeat_reg == LAST_BEAT) ? '0 : ibeat_reg + 1'b1;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                icnt_reg   <= (icnt_reg == LAST_IN) ? '0 : icnt_reg + 1'b1;
            end
        end
    end

    // ---------------- egress serializer ----------------
    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [BIDX_W-1:0] obeat_reg;
    logic [DATA_W-1:0] cap_reg;
    logic [OCNT_W-1:0] ocnt_reg;
    logic              err_reg;
    logic [PAD_W-1:0]  pad_z_reg;
    logic              pad_z_vld_reg;
    logic              pad_z_sof_reg;
    logic              capture;
    logic [PAD_W-1:0]  cap_beats [BEATS];
    logic [PAD_W-1:0]  next_beat;

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_cap
            assign cap_beats[gi] = cap_reg[gi*PAD_W +: PAD_W];
        end
    endgenerate

    // Beat following the one currently on the pads.
    always_comb begin
        next_beat = cap_beats[0];
        for (int i = 1; i < BEATS; i++) begin
            if (obeat_reg == BIDX_W'(i - 1)) begin
                next_beat = cap_beats[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        out_ready  = 1'b0;
        case (state_reg)
            IDLE: begin
                out_ready = 1'b1;
                if (out_valid) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (obeat_reg == LAST_BEAT) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign capture = (state_reg == IDLE) && out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Beat 0 is launched straight from out_data so it appears the cycle after capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            obeat_reg     <= '0;
            cap_reg       <= '0;
            ocnt_reg      <= '0;
            err_reg       <= 1'b0;
            pad_z_reg     <= '0;
            pad_z_vld_reg <= 1'b0;
            pad_z_sof_reg <= 1'b0;
        end else if (capture) begin
            cap_reg       <= out_data;
            obeat_reg     <= '0;
            pad_z_reg     <= out_data[PAD_W-1:0];
            pad_z_vld_reg <= 1'b1;
            pad_z_sof_reg <= (ocnt_reg == '0);
            if (out_last != (ocnt_reg == LAST_OUT)) begin
                err_reg <= 1'b1;
            end
            // A marked last always realigns the tile, even when it came early.
            ocnt_reg <= (out_last || (ocnt_reg == LAST_OUT)) ? '0 : ocnt_reg + 1'b1;
        end else if (state_reg == SEND) begin
            pad_z_sof_reg <= 1'b0;
            if (obeat_reg == LAST_BEAT) begin
                pad_z_vld_reg <= 1'b0;
            end else begin
                obeat_reg <= obeat_reg + 1'b1;
                pad_z_reg <= next_beat;
            end
        end
    end

    assign pad_z     = pad_z_reg;
    assign pad_z_vld = pad_z_vld_reg;
    assign pad_z_sof = pad_z_sof_reg;
    assign err_frame = err_reg;

endmodule

// File: tb/tb_pad_stream_adapter.sv
// Scoreboard bench for pad_stream_adapter: default 10/20 build plus an 8/8 single-beat build.
module tb_pad_stream_adapter;
    localparam int PAD_W    = 10;
    localparam int DATA_W   = 20;
    localparam int BEATS    = DATA_W / PAD_W;
    localparam int TILE_IN  = 16;
    localparam int TILE_OUT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [PAD_W-1:0]  pad_d;
    logic              pad_d_vld;
    logic              pad_d_rdy;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic [PAD_W-1:0]  pad_z;
    logic              pad_z_vld;
    logic              pad_z_sof;
    logic              err_frame;

    logic [7:0] b_pad_d;
    logic       b_pad_d_vld;
    logic       b_pad_d_rdy;
    logic [7:0] b_in_data;
    logic       b_in_valid;
    logic       b_in_ready;
    logic       b_in_last;
    logic [7:0] b_out_data;
    logic       b_out_valid;
    logic       b_out_last;
    logic       b_out_ready;
    logic [7:0] b_pad_z;
    logic       b_pad_z_vld;
    logic       b_pad_z_sof;
    logic       b_err_frame;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] exp_in_q [$];
    logic [PAD_W:0]    exp_out_q [$];
    logic [DATA_W-1:0] asm_m;
    int                mbeat;
    int                in_cnt_m;
    int                out_cnt_m;
    logic              err_m;
    int                n_pop;
    bit                in_hs;
    bit                out_hs;

    always #5 clk = ~clk;

    pad_stream_adapter dut (
        .clk(clk), .rst(rst),
        .pad_d(pad_d), .pad_d_vld(pad_d_vld), .pad_d_rdy(pad_d_rdy),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .pad_z(pad_z), .pad_z_vld(pad_z_vld), .pad_z_sof(pad_z_sof), .err_frame(err_frame)
    );

    pad_stream_adapter #(.PAD_W(8), .DATA_W(8), .TILE_IN(4), .TILE_OUT(4), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .pad_d(b_pad_d), .pad_d_vld(b_pad_d_vld), .pad_d_rdy(b_pad_d_rdy),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_last(b_in_last),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last), .out_ready(b_out_ready),
        .pad_z(b_pad_z), .pad_z_vld(b_pad_z_vld), .pad_z_sof(b_pad_z_sof), .err_frame(b_err_frame)
    );

    // One clock of the main DUT: handshakes are sampled on the falling edge,
    // expected words/beats are queued on acceptance and popped when produced.
    task automatic step();
        logic [DATA_W-1:0] w;
        logic [PAD_W:0]    e;
        in_hs  = 1'b0;
        out_hs = 1'b0;
        @(negedge clk);
        if (rst) begin
            exp_in_q.delete();
            exp_out_q.delete();
            mbeat     = 0;
            asm_m     = '0;
            in_cnt_m  = 0;
            out_cnt_m = 0;
            err_m     = 1'b0;
        end else begin
            tests_run++;
            if (err_frame !== err_m) begin
                tests_failed++;
                $display("FAIL err_frame: got %0b expected %0b", err_frame, err_m);
            end
            if (pad_d_vld && pad_d_rdy) begin
                in_hs = 1'b1;
                asm_m[mbeat*PAD_W +: PAD_W] = pad_d;
                if (mbeat == BEATS - 1) begin
                    exp_in_q.push_back(asm_m);
                    mbeat = 0;
                end else begin
                    mbeat++;
                end
            end
            if (in_valid && in_ready) begin
                tests_run++;
                if (exp_in_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL in_data: unexpected word %05h, none expected", in_data);
                end else begin
                    w = exp_in_q.pop_front();
                    if (in_data !== w) begin
                        tests_failed++;
                        $display("FAIL in_data: got %05h expected %05h", in_data, w);
                    end
                end
                tests_run++;
                if (in_last !== (in_cnt_m == TILE_IN - 1)) begin
                    tests_failed++;
                    $display("FAIL in_last: got %0b expected %0b (word %0d)", in_last, (in_cnt_m == TILE_IN - 1), in_cnt_m);
                end
                in_cnt_m = (in_cnt_m == TILE_IN - 1) ? 0 : in_cnt_m + 1;
                n_pop++;
            end
            if (pad_z_vld) begin
                tests_run++;
                if (exp_out_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL pad_z: unexpected beat %03h sof %0b", pad_z, pad_z_sof);
                end else begin
                    e = exp_out_q.pop_front();
                    if ({pad_z_sof, pad_z} !== e) begin
                        tests_failed++;
                        $display("FAIL pad_z: got beat %03h sof %0b expected beat %03h sof %0b", pad_z, pad_z_sof, e[PAD_W-1:0], e[PAD_W]);
                    end
                end
                tests_run++;
                if (out_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL out_ready_send: got %0b expected 0 while sending", out_ready);
                end
            end
            if (out_valid && out_ready) begin
                out_hs = 1'b1;
                for (int b = 0; b < BEATS; b++) begin
                    exp_out_q.push_back({(b == 0 && out_cnt_m == 0), out_data[b*PAD_W +: PAD_W]});
                end
                if (out_last != (out_cnt_m == TILE_OUT - 1)) err_m = 1'b1;
                out_cnt_m = (out_last || out_cnt_m == TILE_OUT - 1) ? 0 : out_cnt_m + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [PAD_W-1:0] d);
        int guard;
        guard     = 0;
        pad_d     = d;
        pad_d_vld = 1'b1;
        do begin
            step();
            guard++;
        end while (!in_hs && guard < 50);
        if (!in_hs) begin
            tests_run++;
            tests_failed++;
            $display("FAIL beat_timeout: beat %03h not accepted, got no pad_d_rdy within %0d cycles", d, guard);
        end
        pad_d_vld = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic last, output int cycles);
        cycles    = 0;
        out_data  = d;
        out_last  = last;
        out_valid = 1'b1;
        do begin
            step();
            cycles++;
        end while (!out_hs && cycles < 50);
        if (!out_hs) begin
            tests_run++;
            tests_failed++;
            $display("FAIL word_timeout: word %05h not taken, got no out_ready within %0d cycles", d, cycles);
        end
        out_valid = 1'b0;
        out_last  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        tests_run++;
        if (pad_d_rdy !== 1'b1 || in_valid !== 1'b0 || in_last !== 1'b0 || in_data !== '0 ||
            out_ready !== 1'b1 || pad_z !== '0 || pad_z_vld !== 1'b0 || pad_z_sof !== 1'b0 ||
            err_frame !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: got rdy=%0b iv=%0b il=%0b id=%05h or=%0b z=%03h zv=%0b zs=%0b err=%0b expected 1 0 0 00000 1 000 0 0 0",
                     tag, pad_d_rdy, in_valid, in_last, in_data, out_ready, pad_z, pad_z_vld, pad_z_sof, err_frame);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pad_d = '0; pad_d_vld = 1'b0; in_ready = 1'b0;
        out_data = '0; out_valid = 1'b0; out_last = 1'b0;
        b_pad_d = '0; b_pad_d_vld = 1'b0; b_in_ready = 1'b0;
        b_out_data = '0; b_out_valid = 1'b0; b_out_last = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (pad_d_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rdy: got pad_d_rdy=%0b expected 0 during reset", pad_d_rdy);
        end
        step();
        rst = 1'b0;
        #1;
        check_idle_outputs("reset_outputs");
        tests_run++;
        if (b_pad_d_rdy !== 1'b1 || b_in_valid !== 1'b0 || b_out_ready !== 1'b1 || b_pad_z_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_b: got rdy=%0b iv=%0b or=%0b zv=%0b expected 1 0 1 0", b_pad_d_rdy, b_in_valid, b_out_ready, b_pad_z_vld);
        end
    endtask

    task automatic test_stream();
        in_ready = 1'b1;
        n_pop    = 0;
        for (int i = 1; i <= 32; i++) send_beat(PAD_W'(i));
        repeat (4) step();
        tests_run++;
        if (n_pop !== 16 || exp_in_q.size() != 0) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d words (%0d left) expected 16 (0 left)", n_pop, exp_in_q.size());
        end
    endtask

    task automatic test_backpressure();
        in_ready = 1'b0;
        n_pop    = 0;
        for (int i = 0; i < 8; i++) send_beat(PAD_W'(10'h040 + i));
        pad_d     = 10'h048;
        pad_d_vld = 1'b1;
        repeat (3) begin
            tests_run++;
            if (pad_d_rdy !== 1'b0 || in_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_full: got pad_d_rdy=%0b in_valid=%0b expected 0 1", pad_d_rdy, in_valid);
            end
            step();
        end
        in_ready = 1'b1;
        #1;
        tests_run++;
        if (pad_d_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: got pad_d_rdy=%0b expected 1 with pop on full FIFO", pad_d_rdy);
        end
        send_beat(10'h048);
        send_beat(10'h049);
        repeat (8) step();
        tests_run++;
        if (n_pop !== 5 || exp_in_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_drain: got %0d words (%0d left) expected 5 (0 left)", n_pop, exp_in_q.size());
        end
    endtask

    task automatic test_egress();
        logic [DATA_W-1:0] words [4];
        int cyc;
        words = '{20'hAAAAA, 20'h55555, 20'h12345, 20'hFEDCB};
        for (int i = 0; i < 4; i++) begin
            send_word(words[i], (i == 3), cyc);
            if (i > 0) begin
                tests_run++;
                if (cyc != BEATS + 1) begin
                    tests_failed++;
                    $display("FAIL egress_rate: got %0d cycles per word expected %0d", cyc, BEATS + 1);
                end
            end
        end
        repeat (4) step();
        tests_run++;
        if (exp_out_q.size() != 0 || err_frame !== 1'b0) begin
            tests_failed++;
            $display("FAIL egress_done: got %0d beats missing err=%0b expected 0 missing err=0", exp_out_q.size(), err_frame);
        end
    endtask

    task automatic test_frame_err();
        int cyc;
        send_word(20'h11111, 1'b0, cyc);
        send_word(20'h22222, 1'b1, cyc);
        send_word(20'h33333, 1'b0, cyc);
        repeat (4) step();
        send_word(20'h44444, 1'b0, cyc);
        repeat (4) step();
        tests_run++;
        if (err_frame !== 1'b1 || exp_out_q.size() != 0) begin
            tests_failed++;
            $display("FAIL frame_err: got err=%0b with %0d beats missing expected err=1 with 0 missing", err_frame, exp_out_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        in_ready = 1'b0;
        n_pop    = 0;
        send_beat(10'h155);
        send_word(20'h12345, 1'b0, cyc);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_idle_outputs("reset_mid_outputs");
        in_ready = 1'b1;
        send_beat(10'h0AB);
        send_beat(10'h0CD);
        repeat (4) step();
        tests_run++;
        if (n_pop !== 1 || exp_in_q.size() != 0 || exp_out_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_after: got %0d words expected 1 (queues %0d/%0d expected 0/0)", n_pop, exp_in_q.size(), exp_out_q.size());
        end
    endtask

    task automatic test_degenerate();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        b_in_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_pad_d = vals[i];
            b_pad_d_vld = 1'b1;
            @(posedge clk);
            #1;
            tests_run++;
            if (b_in_valid !== 1'b1 || b_in_data !== vals[i] || b_in_last !== (i == 3)) begin
                tests_failed++;
                $display("FAIL deg_word%0d: got v=%0b d=%02h l=%0b expected 1 %02h %0b", i, b_in_valid, b_in_data, b_in_last, vals[i], (i == 3));
            end
        end
        b_pad_d_vld = 1'b0;
        @(posedge clk);
        #1;
        b_in_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_pad_d = 8'h51 + 8'(i);
            b_pad_d_vld = 1'b1;
            @(posedge clk);
            #1;
        end
        b_pad_d = 8'h55;
        tests_run++;
        if (b_pad_d_rdy !== 1'b0 || b_in_data !== 8'h51) begin
            tests_failed++;
            $display("FAIL deg_full: got rdy=%0b head=%02h expected 0 51", b_pad_d_rdy, b_in_data);
        end
        b_in_ready = 1'b1;
        #1;
        tests_run++;
        if (b_pad_d_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL deg_release: got rdy=%0b expected 1", b_pad_d_rdy);
        end
        @(posedge clk);
        #1;
        b_pad_d_vld = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (b_in_valid !== 1'b1 || b_in_data !== 8'h52 + 8'(j) || b_in_last !== (j == 2)) begin
                tests_failed++;
                $display("FAIL deg_drain%0d: got v=%0b d=%02h l=%0b expected 1 %02h %0b", j, b_in_valid, b_in_data, b_in_last, 8'h52 + 8'(j), (j == 2));
            end
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (b_in_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL deg_empty: got in_valid=%0b expected 0", b_in_valid);
        end
        b_out_data  = 8'hA5;
        b_out_valid = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (b_pad_z_vld !== 1'b1 || b_pad_z !== 8'hA5 || b_pad_z_sof !== 1'b1 || b_out_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL deg_out0: got v=%0b z=%02h sof=%0b or=%0b expected 1 a5 1 0", b_pad_z_vld, b_pad_z, b_pad_z_sof, b_out_ready);
        end
        b_out_data = 8'h3C;
        @(posedge clk);
        #1;
        tests_run++;
        if (b_pad_z_vld !== 1'b0 || b_out_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL deg_gap: got v=%0b or=%0b expected 0 1", b_pad_z_vld, b_out_ready);
        end
        @(posedge clk);
        #1;
        b_out_valid = 1'b0;
        tests_run++;
        if (b_pad_z_vld !== 1'b1 || b_pad_z !== 8'h3C || b_pad_z_sof !== 1'b0) begin
            tests_failed++;
            $display("FAIL deg_out1: got v=%0b z=%02h sof=%0b expected 1 3c 0", b_pad_z_vld, b_pad_z, b_pad_z_sof);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (b_pad_z_vld !== 1'b0 || b_pad_z !== 8'h3C || b_err_frame !== 1'b0) begin
            tests_failed++;
            $display("FAIL deg_hold: got v=%0b z=%02h err=%0b expected 0 3c 0", b_pad_z_vld, b_pad_z, b_err_frame);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_egress();
        test_frame_err();
        test_reset_mid();
        test_degenerate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
